// File: rtl/tx_payload_buffer.sv
// ---------------------------------------------------------------------------
// tx_payload_buffer
//
// Byte-wide packet FIFO that feeds the Ethernet TX encapsulation stage.
// The host writes whole packets, framed only by wr_last. A packet becomes
// visible to the reader only once its final byte is accepted and it is at
// least MIN_PCT_BYTES long. The reader sees data first-word-fall-through.
// Reading frees byte space. A rising edge on pct_txed removes one packet
// from the waiting count.
//
// Ports
//   clk           in   single clock (same as the encapsulator TX clock)
//   rst           in   synchronous, active-high reset
//   wr_data[7:0]  in   host byte
//   wr_en         in   host byte valid
//   wr_last       in   final byte of a packet (qualified by wr_en)
//   wr_ready      out  buffer not full (combinational from the pointers)
//   wr_overflow   out  one-cycle pulse when a packet is aborted
//   rd_en         in   encapsulator read enable; advances one byte per cycle
//   rd_data[7:0]  out  byte at the read pointer, 8'h00 when empty
//   pct_count[1:0]out  committed packets waiting, saturated at 3
//   pct_txed      in   packet transmitted; its rising edge releases a packet
//   rd_underflow  out  one-cycle pulse after rd_en was seen while empty
// ---------------------------------------------------------------------------
module tx_payload_buffer #(
  parameter int DEPTH         = 2048,
  parameter int MIN_PCT_BYTES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  input  logic       wr_last,
  output logic       wr_ready,
  output logic       wr_overflow,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic [1:0] pct_count,
  input  logic       pct_txed,
  output logic       rd_underflow
);

  localparam int AW = $clog2(DEPTH);
  // One extra pointer bit tells "full" apart from "empty".
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_DROP = 2'd2
  } wstate_e;

  // Storage is not reset; the pointers alone decide what is valid.
  logic [7:0]    mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;

  logic [PW-1:0] wr_ptr_q,     wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q,     rd_ptr_d;
  logic [PW-1:0] byte_cnt_q,   byte_cnt_d;
  logic [AW-1:0] pkt_cnt_q,    pkt_cnt_d;
  wstate_e       wstate_q,     wstate_d;
  logic          txed_prev_q,  txed_prev_d;
  logic          wr_overflow_q,  wr_overflow_d;
  logic          rd_underflow_q, rd_underflow_d;

  logic [PW-1:0] used;
  logic          full;
  logic          empty;
  logic [PW-1:0] cnt_inc;
  logic          commit;
  logic          release_evt;

  // Occupancy counts uncommitted bytes too, so one in-flight packet can
  // never overwrite data the reader has not consumed yet.
  assign used  = wr_ptr_q - rd_ptr_q;
  assign full  = (used == PW'(DEPTH));
  assign empty = (rd_ptr_q == commit_ptr_q);

  assign wr_ready     = ~full;
  assign wr_overflow  = wr_overflow_q;
  assign rd_underflow = rd_underflow_q;
  assign rd_data      = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign pct_count    = (pkt_cnt_q >= AW'(3)) ? 2'd3 : pkt_cnt_q[1:0];

  assign mem_waddr = wr_ptr_q[AW-1:0];

  // The first byte of a packet restarts the length count.
  assign cnt_inc = (wstate_q == W_IDLE) ? PW'(1) : byte_cnt_q + PW'(1);

  // Writer FSM. Full is judged on the pointers before this cycle's read,
  // so a read in the same cycle does not make room for the write.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    commit_ptr_d  = commit_ptr_q;
    byte_cnt_d    = byte_cnt_q;
    wstate_d      = wstate_q;
    wr_overflow_d = 1'b0;
    commit        = 1'b0;
    mem_we        = 1'b0;

    case (wstate_q)
      W_IDLE, W_DATA: begin
        if (wr_en) begin
          if (full) begin
            // Abort the packet in progress and discard the rest of it.
            wr_ptr_d      = commit_ptr_q;
            wr_overflow_d = 1'b1;
            wstate_d      = wr_last ? W_IDLE : W_DROP;
          end else begin
            mem_we     = 1'b1;
            wr_ptr_d   = wr_ptr_q + PW'(1);
            byte_cnt_d = cnt_inc;
            if (wr_last) begin
              wstate_d = W_IDLE;
              if (cnt_inc >= PW'(MIN_PCT_BYTES)) begin
                commit_ptr_d = wr_ptr_q + PW'(1);
                commit       = 1'b1;
              end else begin
                // Too short to carry even the length field: drop it.
                wr_ptr_d      = commit_ptr_q;
                wr_overflow_d = 1'b1;
              end
            end else begin
              wstate_d = W_DATA;
            end
          end
        end
      end
      W_DROP: begin
        if (wr_en && wr_last) begin
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Reader: never moves past commit_ptr, so uncommitted bytes stay hidden.
  always_comb begin
    rd_ptr_d       = rd_ptr_q;
    rd_underflow_d = 1'b0;
    if (rd_en) begin
      if (empty) begin
        rd_underflow_d = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end
  end

  // Packet count. A commit and a release in the same cycle cancel out.
  assign release_evt = pct_txed & ~txed_prev_q;
  assign txed_prev_d = pct_txed;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (commit && !release_evt) begin
      pkt_cnt_d = pkt_cnt_q + AW'(1);
    end else if (!commit && release_evt && (pkt_cnt_q != '0)) begin
      pkt_cnt_d = pkt_cnt_q - AW'(1);
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      commit_ptr_q   <= '0;
      rd_ptr_q       <= '0;
      byte_cnt_q     <= '0;
      pkt_cnt_q      <= '0;
      wstate_q       <= W_IDLE;
      txed_prev_q    <= 1'b0;
      wr_overflow_q  <= 1'b0;
      rd_underflow_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      commit_ptr_q   <= commit_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      byte_cnt_q     <= byte_cnt_d;
      pkt_cnt_q      <= pkt_cnt_d;
      wstate_q       <= wstate_d;
      txed_prev_q    <= txed_prev_d;
      wr_overflow_q  <= wr_overflow_d;
      rd_underflow_q <= rd_underflow_d;
    end
  end

  // Byte storage
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_tx_payload_buffer.sv
module tb_tx_payload_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       wr_last;
  logic       wr_ready;
  logic       wr_overflow;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [1:0] pct_count;
  logic       pct_txed;
  logic       rd_underflow;

  int total = 0;
  int passed = 0;

  tx_payload_buffer #(.DEPTH(64), .MIN_PCT_BYTES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .wr_last      (wr_last),
    .wr_ready     (wr_ready),
    .wr_overflow  (wr_overflow),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .pct_count    (pct_count),
    .pct_txed     (pct_txed),
    .rd_underflow (rd_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       we;
    logic       wl;
    logic [7:0] wd;
    logic       re;
    logic       pt;
    logic       e_ready;
    logic       e_ovf;
    logic [7:0] e_rd;
    logic [1:0] e_pct;
    logic       e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string nm, logic r, logic we, logic wl, logic [7:0] wd,
                              logic re, logic pt, logic er, logic eo, logic [7:0] erd,
                              logic [1:0] ep, logic eu);
    vec_t v;
    v.name = nm; v.rst = r; v.we = we; v.wl = wl; v.wd = wd; v.re = re; v.pt = pt;
    v.e_ready = er; v.e_ovf = eo; v.e_rd = erd; v.e_pct = ep; v.e_unf = eu;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Apply inputs for one clock and leave them stable until the next call.
  task automatic drive(input logic we, input logic wl, input logic [7:0] wd,
                       input logic re, input logic pt);
    wr_en = we; wr_last = wl; wr_data = wd; rd_en = re; pct_txed = pt;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_pkt(input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) drive(1'b1, i == len - 1, 8'(base + i), 1'b0, 1'b0);
    wr_en = 1'b0; wr_last = 1'b0;
  endtask

  task automatic read_expect(input string nm, input logic [7:0] e);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk(nm, 32'(rd_data), 32'(e));
  endtask

  logic [7:0] seq8[8];
  logic [7:0] seq6[6];
  logic [7:0] pend[$];
  logic [7:0] com[$];
  int ovf_seen;
  int wi;
  int nread;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_last = 1'b0; wr_data = 8'h00; rd_en = 1'b0; pct_txed = 1'b0;

    // name, rst, we, wl, wd, re, pt | ready, ovf, rd_data, pct, unf
    add("reset",       1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0);
    add("reset2",      1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0);
    add("wr_00",       0, 1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0);
    add("wr_04",       0, 1, 0, 8'h04, 0, 0, 1, 0, 8'h00, 0, 0);
    add("wr_A1",       0, 1, 0, 8'hA1, 0, 0, 1, 0, 8'h00, 0, 0);
    add("wr_B2",       0, 1, 0, 8'hB2, 0, 0, 1, 0, 8'h00, 0, 0);
    add("wr_C3",       0, 1, 0, 8'hC3, 0, 0, 1, 0, 8'h00, 0, 0);
    add("wr_D4_last",  0, 1, 1, 8'hD4, 0, 0, 1, 0, 8'h00, 1, 0);
    add("rd_1",        0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h04, 1, 0);
    add("rd_2",        0, 0, 0, 8'h00, 1, 0, 1, 0, 8'hA1, 1, 0);
    add("rd_3",        0, 0, 0, 8'h00, 1, 0, 1, 0, 8'hB2, 1, 0);
    add("rd_4",        0, 0, 0, 8'h00, 1, 0, 1, 0, 8'hC3, 1, 0);
    add("rd_5",        0, 0, 0, 8'h00, 1, 0, 1, 0, 8'hD4, 1, 0);
    add("rd_6_empty",  0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 1, 0);
    add("rd_underflow",0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 1, 1);
    add("idle",        0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 1, 0);
    add("release",     0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);
    add("release_hold",0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);
    add("release_low", 0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0);
    add("short_pkt",   0, 1, 1, 8'h55, 0, 0, 1, 1, 8'h00, 0, 0);
    add("after_short", 0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0);
    add("p3_b0",       0, 1, 0, 8'h11, 0, 0, 1, 0, 8'h00, 0, 0);
    add("p3_b1",       0, 1, 0, 8'h22, 0, 0, 1, 0, 8'h00, 0, 0);
    add("p3_b2_last",  0, 1, 1, 8'h33, 0, 0, 1, 0, 8'h11, 1, 0);
    add("p3_rd1",      0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h22, 1, 0);
    add("p3_rd2",      0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h33, 1, 0);
    add("p3_rd3",      0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 1, 0);
    add("p3_release",  0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);
    add("p3_rel_low",  0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0);
    add("mid_wr",      0, 1, 0, 8'h99, 0, 0, 1, 0, 8'h00, 0, 0);
    add("mid_rst",     1, 1, 0, 8'h98, 0, 0, 1, 0, 8'h00, 0, 0);
    add("post_rst_b0", 0, 1, 0, 8'h61, 0, 0, 1, 0, 8'h00, 0, 0);
    add("post_rst_b1", 0, 1, 1, 8'h62, 0, 0, 1, 0, 8'h61, 1, 0);
    add("post_rst_rd1",0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h62, 1, 0);
    add("post_rst_rd2",0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 1, 0);
    add("post_rst_rel",0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);
    add("post_rst_lo", 0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      drive(vecs[i].we, vecs[i].wl, vecs[i].wd, vecs[i].re, vecs[i].pt);
      chk({vecs[i].name, ".wr_ready"},     32'(wr_ready),     32'(vecs[i].e_ready));
      chk({vecs[i].name, ".wr_overflow"},  32'(wr_overflow),  32'(vecs[i].e_ovf));
      chk({vecs[i].name, ".rd_data"},      32'(rd_data),      32'(vecs[i].e_rd));
      chk({vecs[i].name, ".pct_count"},    32'(pct_count),    32'(vecs[i].e_pct));
      chk({vecs[i].name, ".rd_underflow"}, 32'(rd_underflow), 32'(vecs[i].e_unf));
    end
    rst = 1'b0;

    // Four committed packets, then five release pulses.
    wr_pkt(2, 8'h10); chk("four.pct_after_1", 32'(pct_count), 32'd1);
    wr_pkt(2, 8'h20); chk("four.pct_after_2", 32'(pct_count), 32'd2);
    wr_pkt(2, 8'h30); chk("four.pct_after_3", 32'(pct_count), 32'd3);
    wr_pkt(2, 8'h40); chk("four.pct_after_4", 32'(pct_count), 32'd3);
    begin
      logic [1:0] exp_pct[5];
      exp_pct = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
      for (int p = 0; p < 5; p++) begin
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk($sformatf("four.pulse%0d_pct", p), 32'(pct_count), 32'(exp_pct[p]));
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk($sformatf("four.pulse%0d_low_pct", p), 32'(pct_count), 32'(exp_pct[p]));
      end
    end
    chk("four.head", 32'(rd_data), 32'h10);
    seq8 = '{8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h40, 8'h41, 8'h00};
    for (int i = 0; i < 8; i++) read_expect($sformatf("four.rd%0d", i), seq8[i]);

    // Oversized packet: 70 bytes into 64 bytes of storage.
    ovf_seen = 0;
    for (int k = 1; k <= 70; k++) begin
      drive(1'b1, k == 70, 8'(k), 1'b0, 1'b0);
      ovf_seen += int'(wr_overflow);
      if (k == 63) chk("big.ready_byte63", 32'(wr_ready), 32'd1);
      if (k == 64) chk("big.ready_byte64", 32'(wr_ready), 32'd0);
      if (k == 65) chk("big.ovf_byte65", 32'(wr_overflow), 32'd1);
    end
    wr_en = 1'b0; wr_last = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("big.ovf_pulses", 32'(ovf_seen), 32'd1);
    chk("big.pct", 32'(pct_count), 32'd0);
    chk("big.empty_rd", 32'(rd_data), 32'h00);
    chk("big.ready_after", 32'(wr_ready), 32'd1);
    wr_pkt(3, 8'h70);
    chk("big.next_pct", 32'(pct_count), 32'd1);
    chk("big.next_head", 32'(rd_data), 32'h70);
    read_expect("big.next_rd1", 8'h71);
    read_expect("big.next_rd2", 8'h72);
    read_expect("big.next_rd3", 8'h00);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("big.released", 32'(pct_count), 32'd0);

    // Commit coinciding with a release, then read underflow.
    wr_pkt(2, 8'hA0);
    wr_pkt(2, 8'hB0);
    chk("sim.pct_before", 32'(pct_count), 32'd2);
    drive(1'b1, 1'b0, 8'hC0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'hC1, 1'b0, 1'b1);
    chk("sim.pct_same_edge", 32'(pct_count), 32'd2);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("sim.pct_after", 32'(pct_count), 32'd2);
    chk("sim.head", 32'(rd_data), 32'hA0);
    seq6 = '{8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'h00};
    for (int i = 0; i < 6; i++) read_expect($sformatf("sim.rd%0d", i), seq6[i]);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("sim.underflow", 32'(rd_underflow), 32'd1);
    chk("sim.underflow_rd", 32'(rd_data), 32'h00);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("sim.underflow_clear", 32'(rd_underflow), 32'd0);
    wr_pkt(2, 8'hD0);
    chk("sim.rdptr_held", 32'(rd_data), 32'hD0);
    read_expect("sim.d_rd1", 8'hD1);
    read_expect("sim.d_rd2", 8'h00);

    // Streaming across the pointer wrap with concurrent reads.
    pend.delete(); com.delete();
    wi = 0; nread = 0; ovf_seen = 0;
    for (int c = 0; c < 600 && (wi < 200 || com.size() > 0); c++) begin
      logic       we, wl, re;
      logic [7:0] wd;
      we = (wi < 200);
      wl = we && (wi % 20 == 19);
      wd = 8'(wi * 7 + 3);
      re = (com.size() > 0);
      drive(we, wl, wd, re, 1'b0);
      if (re) begin void'(com.pop_front()); nread++; end
      if (we) begin
        pend.push_back(wd);
        if (wl) begin
          foreach (pend[j]) com.push_back(pend[j]);
          pend.delete();
        end
        wi++;
      end
      chk($sformatf("wrap.rd_c%0d", c), 32'(rd_data),
          32'((com.size() > 0) ? com[0] : 8'h00));
      ovf_seen += int'(wr_overflow);
    end
    wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0;
    chk("wrap.bytes_read", 32'(nread), 32'd200);
    chk("wrap.no_overflow", 32'(ovf_seen), 32'd0);
    chk("wrap.pct_sat", 32'(pct_count), 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
